// File: rtl/sd_field_loader.sv
// -----------------------------------------------------------------------------
// sd_field_loader
//
// Loads a Game-of-Life field image from the SD card into grid RAM. A load reads
// NUM_BLOCKS consecutive 512-byte blocks starting at base_block. Each byte is
// unpacked LSB first into 8 single-cell writes, so one block fills 4096 cells.
//
// Ports
//   clk_spi      in   1       sole clock (SPI-domain clock)
//   reset        in   1       synchronous, active-high
//   start        in   1       one-cycle load request, sampled only while idle
//   base_block   in   32      first block id, captured on an accepted start
//   block_id     out  32      id of the block currently requested
//   blk_execute  out  1       one-cycle pulse: begin read of block_id
//   in_data      in   8       byte from the block reader
//   in_valid     in   1       in_data valid, held by the producer until taken
//   in_ready     out  1       loader can take a byte this cycle
//   cell_addr    out  ADDR_W  grid RAM write address
//   cell_data    out  1       grid RAM write data
//   cell_we      out  1       grid RAM write enable
//   busy         out  1       high from accepted start until the load ends
//   done         out  1       one-cycle pulse after the last cell write
//
// All outputs are registered: the next-state process computes the value each
// output takes in the following cycle, so an output is high exactly while the
// FSM sits in the state that owns it.
// -----------------------------------------------------------------------------
module sd_field_loader #(
    parameter int NUM_BLOCKS = 1,
    parameter int ADDR_W     = 12,
    parameter int INVERT     = 0
) (
    input  logic              clk_spi,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       base_block,
    output logic [31:0]       block_id,
    output logic              blk_execute,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] cell_addr,
    output logic              cell_data,
    output logic              cell_we,
    output logic              busy,
    output logic              done
);

    localparam int                BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [8:0]        LAST_BYTE = 9'd511;
    localparam logic [2:0]        LAST_BIT  = 3'd7;
    localparam logic              INV       = (INVERT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RECV,
        S_UNPACK,
        S_DONE
    } state_t;

    // Card polarity: some images store 0 = alive, so the bit may be flipped
    // on its way to the grid.
    function automatic logic cell_bit(input logic b);
        return b ^ INV;
    endfunction

    state_t             state, state_nxt;

    logic [31:0]        base_q, base_nxt;
    logic [7:0]         shift_q, shift_nxt;

    logic [BLK_W-1:0]   blk_idx, blk_idx_nxt;
    logic [8:0]         byte_cnt, byte_cnt_nxt;
    logic [2:0]         bit_cnt, bit_cnt_nxt;

    logic [31:0]        block_id_nxt;
    logic               blk_execute_nxt;
    logic               in_ready_nxt;
    logic [ADDR_W-1:0]  cell_addr_nxt;
    logic               cell_data_nxt;
    logic               cell_we_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    // Control state, counters and every output register.
    always_ff @(posedge clk_spi) begin
        if (reset) begin
            state       <= S_IDLE;
            blk_idx     <= '0;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            block_id    <= '0;
            blk_execute <= 1'b0;
            in_ready    <= 1'b0;
            cell_addr   <= '0;
            cell_data   <= 1'b0;
            cell_we     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            blk_idx     <= blk_idx_nxt;
            byte_cnt    <= byte_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            block_id    <= block_id_nxt;
            blk_execute <= blk_execute_nxt;
            in_ready    <= in_ready_nxt;
            cell_addr   <= cell_addr_nxt;
            cell_data   <= cell_data_nxt;
            cell_we     <= cell_we_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Pure data holding registers; their contents only matter once the FSM
    // has loaded them, so they carry no reset.
    always_ff @(posedge clk_spi) begin
        base_q  <= base_nxt;
        shift_q <= shift_nxt;
    end

    always_comb begin
        state_nxt       = state;
        base_nxt        = base_q;
        shift_nxt       = shift_q;
        blk_idx_nxt     = blk_idx;
        byte_cnt_nxt    = byte_cnt;
        bit_cnt_nxt     = bit_cnt;
        block_id_nxt    = block_id;
        blk_execute_nxt = 1'b0;
        in_ready_nxt    = 1'b0;
        cell_addr_nxt   = cell_addr;
        cell_data_nxt   = cell_data;
        cell_we_nxt     = 1'b0;
        busy_nxt        = busy;
        done_nxt        = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    base_nxt        = base_block;
                    blk_idx_nxt     = '0;
                    cell_addr_nxt   = '0;
                    // First block is base + 0; issue it on entry to ISSUE.
                    block_id_nxt    = base_block;
                    blk_execute_nxt = 1'b1;
                    busy_nxt        = 1'b1;
                    state_nxt       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                byte_cnt_nxt = '0;
                in_ready_nxt = 1'b1;
                state_nxt    = S_RECV;
            end

            S_RECV: begin
                // in_ready is the registered "in RECV" flag, so the handshake
                // uses exactly what the producer sees.
                if (in_valid && in_ready) begin
                    cell_we_nxt   = 1'b1;
                    cell_data_nxt = cell_bit(in_data[0]);
                    shift_nxt     = in_data >> 1;
                    bit_cnt_nxt   = '0;
                    state_nxt     = S_UNPACK;
                end else begin
                    in_ready_nxt  = 1'b1;
                end
            end

            S_UNPACK: begin
                // The write presented this cycle targets cell_addr; advance
                // for the next bit (or the next byte).
                cell_addr_nxt = cell_addr + 1'b1;
                if (bit_cnt != LAST_BIT) begin
                    cell_we_nxt   = 1'b1;
                    cell_data_nxt = cell_bit(shift_q[0]);
                    shift_nxt     = shift_q >> 1;
                    bit_cnt_nxt   = bit_cnt + 3'd1;
                end else if (byte_cnt != LAST_BYTE) begin
                    byte_cnt_nxt  = byte_cnt + 9'd1;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = S_RECV;
                end else if (blk_idx != LAST_BLK) begin
                    blk_idx_nxt     = blk_idx + 1'b1;
                    // 32-bit add: a base near the top of the id space wraps.
                    block_id_nxt    = base_q + 32'(blk_idx_nxt);
                    blk_execute_nxt = 1'b1;
                    state_nxt       = S_ISSUE;
                end else begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_field_loader.sv
// -----------------------------------------------------------------------------
// Bench for sd_field_loader. Two instances: dut_a (1 block, 12-bit address,
// normal polarity) and dut_b (2 blocks, 13-bit address, inverted polarity).
// One set of driving variables is routed to whichever instance sel picks.
// The expected grid contents come straight from the source image: cell i holds
// bit (i % 8) of byte (i / 8), optionally inverted, at address i.
// -----------------------------------------------------------------------------
module tb_sd_field_loader;

    logic clk;
    logic reset;
    logic sel;
    logic start;
    logic [31:0] base_block;
    logic [7:0]  in_data;
    logic        in_valid;

    logic a_start, a_in_valid, b_start, b_in_valid;
    logic [31:0] a_block_id, b_block_id;
    logic a_blk_execute, a_in_ready, a_cell_data, a_cell_we, a_busy, a_done;
    logic b_blk_execute, b_in_ready, b_cell_data, b_cell_we, b_busy, b_done;
    logic [11:0] a_cell_addr;
    logic [12:0] b_cell_addr;

    logic [31:0] cur_block_id;
    logic        cur_blk_execute, cur_in_ready, cur_cell_data, cur_cell_we, cur_busy, cur_done;
    logic [12:0] cur_cell_addr;

    assign a_start    = start & ~sel;
    assign a_in_valid = in_valid & ~sel;
    assign b_start    = start & sel;
    assign b_in_valid = in_valid & sel;

    assign cur_block_id    = sel ? b_block_id    : a_block_id;
    assign cur_blk_execute = sel ? b_blk_execute : a_blk_execute;
    assign cur_in_ready    = sel ? b_in_ready    : a_in_ready;
    assign cur_cell_addr   = sel ? b_cell_addr   : {1'b0, a_cell_addr};
    assign cur_cell_data   = sel ? b_cell_data   : a_cell_data;
    assign cur_cell_we     = sel ? b_cell_we     : a_cell_we;
    assign cur_busy        = sel ? b_busy        : a_busy;
    assign cur_done        = sel ? b_done        : a_done;

    sd_field_loader #(.NUM_BLOCKS(1), .ADDR_W(12), .INVERT(0)) dut_a (
        .clk_spi(clk), .reset(reset), .start(a_start), .base_block(base_block),
        .block_id(a_block_id), .blk_execute(a_blk_execute),
        .in_data(in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .cell_addr(a_cell_addr), .cell_data(a_cell_data), .cell_we(a_cell_we),
        .busy(a_busy), .done(a_done)
    );

    sd_field_loader #(.NUM_BLOCKS(2), .ADDR_W(13), .INVERT(1)) dut_b (
        .clk_spi(clk), .reset(reset), .start(b_start), .base_block(base_block),
        .block_id(b_block_id), .blk_execute(b_blk_execute),
        .in_data(in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .cell_addr(b_cell_addr), .cell_data(b_cell_data), .cell_we(b_cell_we),
        .busy(b_busy), .done(b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  img [0:1023];
    logic [31:0] load_base;

    // Observed traffic of the selected instance.
    logic [12:0] wq_addr [$];
    logic        wq_data [$];
    logic [31:0] eq_id   [$];
    int          done_cnt = 0;
    int          w0, e0, d0;

    always @(negedge clk) begin
        if (cur_cell_we === 1'b1) begin
            wq_addr.push_back(cur_cell_addr);
            wq_data.push_back(cur_cell_data);
        end
        if (cur_blk_execute === 1'b1) eq_id.push_back(cur_block_id);
        if (cur_done === 1'b1) done_cnt++;
    end

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
    endtask

    // Drive one load on the selected instance. Returns the number of cycles
    // from the start pulse to the first cycle done is seen. With abort_byte
    // >= 0 it returns at the first unpack cycle of that byte instead.
    task automatic run_load(input int nblk, input int pct, input int mid_start,
                            input int abort_byte, output int cyc, output bit aborted);
        int idx;
        bit acc;
        bit fin;
        int total;
        idx = 0; acc = 0; fin = 0; cyc = 0; aborted = 0;
        total = nblk * 512;
        w0 = wq_addr.size(); e0 = eq_id.size(); d0 = done_cnt;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base_block = load_base;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (mid_start > 0 && cyc == mid_start) begin
                start = 1'b1;
                base_block = $urandom;
            end
            if (mid_start > 0 && cyc == mid_start + 1) begin
                start = 1'b0;
                n_cmp++;
                if (cur_busy !== 1'b1 || cur_block_id !== load_base) begin
                    n_bad++;
                    $display("FAIL start_ignored busy=%0b block_id=%h, required busy=1 block_id=%h",
                             cur_busy, cur_block_id, load_base);
                end
            end
            if (cur_done === 1'b1) begin
                fin = 1;
            end else if (cyc > 20 * total + 100) begin
                n_cmp++; n_bad++;
                $display("FAIL load_timeout no done after %0d cycles", cyc);
                fin = 1;
            end else begin
                if (acc) idx++;
                if (acc && abort_byte >= 0 && idx - 1 == abort_byte) begin
                    aborted = 1;
                    fin = 1;
                end else begin
                    in_data = (idx < total) ? img[idx] : 8'h00;
                    if (!in_valid || acc)
                        in_valid = (idx < total) && ($urandom_range(99) < pct);
                    acc = in_valid && (cur_in_ready === 1'b1);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Compare the recorded traffic of the last load against the image.
    task automatic check_load(input int nblk, input logic inv, input string tag);
        int nw;
        logic exp_d;
        logic [31:0] exp_id;
        repeat (4) @(negedge clk);
        nw = nblk * 4096;
        n_cmp++;
        if (wq_addr.size() - w0 != nw) begin
            n_bad++;
            $display("FAIL %s write_count got %0d required %0d", tag, wq_addr.size() - w0, nw);
        end
        for (int i = 0; i < nw && w0 + i < wq_addr.size(); i++) begin
            exp_d = img[i / 8][i % 8] ^ inv;
            n_cmp++;
            if (wq_addr[w0 + i] !== 13'(i) || wq_data[w0 + i] !== exp_d) begin
                n_bad++;
                if (n_bad < 20)
                    $display("FAIL %s write[%0d] got addr=%0d data=%0b required addr=%0d data=%0b",
                             tag, i, wq_addr[w0 + i], wq_data[w0 + i], i, exp_d);
            end
        end
        n_cmp++;
        if (eq_id.size() - e0 != nblk) begin
            n_bad++;
            $display("FAIL %s execute_count got %0d required %0d", tag, eq_id.size() - e0, nblk);
        end
        for (int k = 0; k < nblk && e0 + k < eq_id.size(); k++) begin
            exp_id = load_base + 32'(k);
            n_cmp++;
            if (eq_id[e0 + k] !== exp_id) begin
                n_bad++;
                $display("FAIL %s block_id[%0d] got %h required %h", tag, k, eq_id[e0 + k], exp_id);
            end
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || cur_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_pulses got %0d busy=%0b required 1 pulse busy=0",
                     tag, done_cnt - d0, cur_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        base_block = 32'h0; sel = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_block_id, a_blk_execute, a_in_ready, a_cell_addr, a_cell_data,
             a_cell_we, a_busy, a_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_a outputs id=%h addr=%h busy=%0b ready=%0b we=%0b, required all 0",
                     a_block_id, a_cell_addr, a_busy, a_in_ready, a_cell_we);
        end
        n_cmp++;
        if ({b_block_id, b_blk_execute, b_in_ready, b_cell_addr, b_cell_data,
             b_cell_we, b_busy, b_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_b outputs id=%h addr=%h busy=%0b ready=%0b we=%0b, required all 0",
                     b_block_id, b_cell_addr, b_busy, b_in_ready, b_cell_we);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b0 || a_in_ready !== 1'b0 || b_busy !== 1'b0 || b_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset busy=%0b/%0b ready=%0b/%0b required 0",
                     a_busy, b_busy, a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_single_block();
        int cyc;
        bit ab;
        sel = 1'b0;
        for (int i = 0; i < 1024; i++) img[i] = 8'hA5;
        load_base = 32'd100;
        run_load(1, 100, 0, -1, cyc, ab);
        n_cmp++;
        if (cyc != 9 * 512 + 2) begin
            n_bad++;
            $display("FAIL single_latency got %0d cycles required %0d", cyc, 9 * 512 + 2);
        end
        check_load(1, 1'b0, "single_block");
    endtask

    task automatic test_wrap_two_blocks();
        int cyc;
        bit ab;
        sel = 1'b1;
        fill_random();
        load_base = 32'hFFFF_FFFF;
        run_load(2, 100, 0, -1, cyc, ab);
        check_load(2, 1'b1, "wrap_two_blocks");
        n_cmp++;
        if (eq_id.size() < e0 + 2 || eq_id[e0] !== 32'hFFFF_FFFF || eq_id[e0 + 1] !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_ids got %0d ids, required FFFFFFFF then 00000000", eq_id.size() - e0);
        end
    endtask

    task automatic test_random_valid();
        int cyc;
        bit ab;
        sel = 1'b1;
        fill_random();
        load_base = $urandom;
        run_load(2, 50, 0, -1, cyc, ab);
        check_load(2, 1'b1, "random_valid");
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit ab;
        sel = 1'b0;
        fill_random();
        load_base = $urandom;
        run_load(1, 100, 1000, -1, cyc, ab);
        check_load(1, 1'b0, "start_ignored");
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ab;
        int wsnap;
        sel = 1'b0;
        fill_random();
        load_base = $urandom;
        run_load(1, 100, 0, 200, cyc, ab);
        n_cmp++;
        if (ab !== 1'b1 || cur_cell_we !== 1'b1 || cur_cell_addr !== 13'd1600) begin
            n_bad++;
            $display("FAIL abort_point reached=%0b we=%0b addr=%0d required 1/1/1600",
                     ab, cur_cell_we, cur_cell_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cur_block_id, cur_blk_execute, cur_in_ready, cur_cell_addr, cur_cell_data,
             cur_cell_we, cur_busy, cur_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid outputs id=%h addr=%0d we=%0b busy=%0b, required all 0",
                     cur_block_id, cur_cell_addr, cur_cell_we, cur_busy);
        end
        reset = 1'b0;
        @(negedge clk);
        wsnap = wq_addr.size();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wq_addr.size() != wsnap || done_cnt != d0 || cur_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_quiet writes=%0d done=%0d busy=%0b required 0/0/0",
                     wq_addr.size() - wsnap, done_cnt - d0, cur_busy);
        end
        fill_random();
        load_base = $urandom;
        run_load(1, 100, 0, -1, cyc, ab);
        check_load(1, 1'b0, "reload_after_reset");
    endtask

    task automatic test_invert();
        int cyc;
        bit ab;
        logic [7:0] pat;
        sel = 1'b1;
        fill_random();
        img[0] = 8'h0F;
        pat = 8'hF0;
        load_base = 32'd7;
        run_load(2, 100, 0, -1, cyc, ab);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wq_addr.size() <= w0 + i || wq_addr[w0 + i] !== 13'(i) || wq_data[w0 + i] !== pat[i]) begin
                n_bad++;
                $display("FAIL invert_bit[%0d] got %0b required %0b", i,
                         (wq_data.size() > w0 + i) ? wq_data[w0 + i] : 1'bx, pat[i]);
            end
        end
        check_load(2, 1'b1, "invert");
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_wrap_two_blocks();
        test_random_valid();
        test_start_ignored();
        test_reset_mid();
        test_invert();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
